// File: rtl/pong_output_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : pong_pio_pkg
//  Purpose   : Shared register offsets for the pong output PIO slave.
//  Revision  : 1.0  initial release
// ============================================================================
package pong_pio_pkg;

  // Word offsets of the PIO registers on the Avalon-MM slave
  localparam logic [2:0] DATA      = 3'd0;
  localparam logic [2:0] PULSE_LEN = 3'd1;
  localparam logic [2:0] PULSE     = 3'd2;
  localparam logic [2:0] OUTSET    = 3'd4;
  localparam logic [2:0] OUTCLEAR  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/pong_output_pio_if.sv
`default_nettype none
// ============================================================================
//  Interface : pong_output_pio_if
//  Purpose   : Avalon-MM slave bus bundle (address/select/write/data/readdata).
//  Revision  : 1.0  initial release
// ============================================================================
interface pong_output_pio_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  // Bus master (Nios II / interconnect side)
  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  // PIO slave side
  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface
`default_nettype wire

// File: rtl/pong_output_pio_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module    : pong_pulse_timer
//  Purpose   : Self-clearing pulse mask. A load ORs new bits into the mask and
//              (re)starts the down-counter at plen; the mask clears on the edge
//              where the counter leaves 1, so a fresh pulse lasts plen cycles.
//  Revision  : 1.0  initial release
// ============================================================================
module pong_pulse_timer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_mask,
  input  logic [CNT_W-1:0] plen,
  output logic [WIDTH-1:0] mask
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mask;

  // Counter/mask update: a load wins over expiry, so a write on the last
  // active cycle extends the pulse instead of letting it drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_mask <= '0;
    end else if (load) begin
      r_mask <= r_mask | load_mask;
      r_cnt  <= plen;
    end else if (r_cnt == C_ONE) begin
      r_cnt  <= '0;
      r_mask <= '0;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - C_ONE;
    end
  end

  assign mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/pong_output_pio.sv
`default_nettype none
// ============================================================================
//  Module    : pong_output_pio
//  Purpose   : Avalon-MM output PIO for the pong board: direct data writes,
//              atomic bit set/clear and self-clearing timed pulses driven onto
//              out_port = data_reg | pulse_mask.
//  Revision  : 1.0  initial release
// ============================================================================
module pong_output_pio
  import pong_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 16,
  parameter int PULSE_RST = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  pong_output_pio_if.slave bus,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [CNT_W-1:0] C_PLEN_RST = CNT_W'(PULSE_RST);

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [CNT_W-1:0] w_wd_cnt;
  logic             w_load;
  logic [WIDTH-1:0] w_mask;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_plen;

  assign w_wr     = bus.chipselect & ~bus.write_n;
  assign w_wd     = bus.writedata[WIDTH-1:0];
  assign w_wd_cnt = bus.writedata[CNT_W-1:0];
  // Upper writedata bits are intentionally dropped
  assign w_unused = &{1'b0, bus.writedata};

  // A pulse request with no bits or a zero length does nothing at all
  assign w_load = w_wr && (bus.address == PULSE) && (w_wd != '0) && (r_plen != '0);

  // Output data register: direct write, atomic set and atomic clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (w_wr) begin
      case (bus.address)
        DATA:     r_data <= w_wd;
        OUTSET:   r_data <= r_data | w_wd;
        OUTCLEAR: r_data <= r_data & ~w_wd;
        default:  r_data <= r_data;
      endcase
    end
  end

  // Pulse length register; only sampled by the timer on the next reload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_plen <= C_PLEN_RST;
    end else if (w_wr && (bus.address == PULSE_LEN)) begin
      r_plen <= w_wd_cnt;
    end
  end

  pong_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_pulse_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (w_load),
    .load_mask (w_wd),
    .plen      (r_plen),
    .mask      (w_mask)
  );

  // Zero-extended read mux; unmapped offsets read as zero
  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      DATA:      w_rd_mux[WIDTH-1:0] = r_data;
      PULSE_LEN: w_rd_mux[CNT_W-1:0] = r_plen;
      PULSE:     w_rd_mux[WIDTH-1:0] = w_mask;
      default:   w_rd_mux = '0;
    endcase
  end

  // Read data is registered every cycle independent of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= w_rd_mux;
    end
  end

  assign out_port = r_data | w_mask;

endmodule
`default_nettype wire

// File: tb/tb_pong_output_pio.sv
`default_nettype none
// ============================================================================
//  Module    : tb_pong_output_pio
//  Purpose   : Self-checking bench for pong_output_pio with a cycle-level
//              reference model (pulse expiry tracked as an absolute cycle).
//  Revision  : 1.0  initial release
// ============================================================================
module tb_pong_output_pio;

  localparam int WIDTH     = 8;
  localparam int CNT_W     = 16;
  localparam int PULSE_RST = 1000;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] out_port;

  pong_output_pio_if bus ();

  pong_output_pio #(
    .WIDTH     (WIDTH),
    .CNT_W     (CNT_W),
    .PULSE_RST (PULSE_RST)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_mask;
  logic [CNT_W-1:0] m_plen;
  logic [31:0]      m_rd;
  bit               m_active;
  int               m_expire;
  int               cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data   = '0;
    m_mask   = '0;
    m_plen   = CNT_W'(PULSE_RST);
    m_rd     = '0;
    m_active = 1'b0;
    m_expire = 0;
  endtask

  // One clock edge: advance the model with the bus as driven, then compare
  task automatic tick();
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [31:0]      rd;
    @(posedge clk);
    cyc++;
    wr = bus.chipselect && !bus.write_n;
    wd = bus.writedata[WIDTH-1:0];
    case (bus.address)
      3'd0:    rd = 32'(m_data);
      3'd1:    rd = 32'(m_plen);
      3'd2:    rd = 32'(m_mask);
      default: rd = 32'd0;
    endcase
    if (wr && bus.address == 3'd2 && wd != 0 && m_plen != 0) begin
      m_mask   = m_mask | wd;
      m_active = 1'b1;
      m_expire = cyc + int'(m_plen);
    end else if (m_active && cyc == m_expire) begin
      m_mask   = '0;
      m_active = 1'b0;
    end
    if (wr) begin
      case (bus.address)
        3'd0: m_data = wd;
        3'd1: m_plen = bus.writedata[CNT_W-1:0];
        3'd4: m_data = m_data | wd;
        3'd5: m_data = m_data & ~wd;
        default: ;
      endcase
    end
    m_rd = rd;
    @(negedge clk);
    check("out_port", 32'(out_port), 32'(m_data | m_mask));
    check("readdata", bus.readdata, m_rd);
  endtask

  task automatic write(input logic [2:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic idle(input logic [2:0] addr, input int n);
    bus.address    = addr;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    check("rst_out_port", 32'(out_port), 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    idle(3'd0, 1);
    check("rst_data_rd", bus.readdata, 32'h0);
    idle(3'd1, 1);
    check("rst_plen_rd", bus.readdata, 32'd1000);

    // Data, set, clear
    write(3'd0, 32'hFFFF_FFA5);
    check("data_wr", 32'(out_port), 32'hA5);
    write(3'd4, 32'h0F);
    check("outset", 32'(out_port), 32'hAF);
    write(3'd5, 32'h81);
    check("outclear", 32'(out_port), 32'h2E);
    idle(3'd0, 1);
    check("data_rd", bus.readdata, 32'h2E);

    // Fresh pulse of 4 cycles
    write(3'd1, 32'd4);
    write(3'd0, 32'd0);
    write(3'd2, 32'h03);
    check("pulse_c1", 32'(out_port), 32'h03);
    idle(3'd2, 3);
    check("pulse_c4", 32'(out_port), 32'h03);
    check("pulse_rd", bus.readdata, 32'h03);
    idle(3'd2, 1);
    check("pulse_end", 32'(out_port), 32'h00);

    // Re-pulse landing on the last active cycle extends all bits
    write(3'd2, 32'h01);
    idle(3'd2, 3);
    write(3'd2, 32'h04);
    check("extend_c1", 32'(out_port), 32'h05);
    idle(3'd0, 3);
    check("extend_c4", 32'(out_port), 32'h05);
    idle(3'd0, 1);
    check("extend_end", 32'(out_port), 32'h00);

    // Zero length pulse and unmapped offsets
    write(3'd0, 32'h3C);
    write(3'd1, 32'd0);
    write(3'd2, 32'hFF);
    check("zero_len", 32'(out_port), 32'h3C);
    write(3'd6, 32'hFF);
    check("addr6_wr", 32'(out_port), 32'h3C);
    idle(3'd6, 1);
    check("addr6_rd", bus.readdata, 32'h0);
    idle(3'd3, 1);
    idle(3'd7, 1);

    // Reset in the middle of a long pulse
    write(3'd0, 32'd0);
    write(3'd1, 32'd100);
    write(3'd2, 32'h80);
    idle(3'd0, 9);
    check("mid_pulse", 32'(out_port), 32'h80);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out_port), 32'h0);
    check("async_rst_rd", bus.readdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(3'd1, 1);
    check("post_rst_plen", bus.readdata, 32'd1000);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [2:0]  a;
      logic [31:0] d;
      r = $urandom_range(0, 9);
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
      if (a == 3'd2 && $urandom_range(0, 7) == 0) d = d & 32'hFFFF_FF00;
      if (r < 6) begin
        write(a, d);
      end else begin
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = (r == 9);
        bus.write_n    = (r != 8);
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
